// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit (master) and mult_div_unit (slave).
// With MULTDIV_UNSIGNED_EN defined the bundle also carries the is_unsigned qualifier.
interface mult_div_unit_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] A_in;
    logic [DATA_W-1:0] B_in;
    logic              start_mult;
    logic              start_div;
    logic [DATA_W-1:0] HI_out;
    logic [DATA_W-1:0] LO_out;
    logic              busy;
    logic              done;
    logic              div_zero;
`ifdef MULTDIV_UNSIGNED_EN
    logic              is_unsigned;

    modport master (
        output A_in, B_in, start_mult, start_div, is_unsigned,
        input  HI_out, LO_out, busy, done, div_zero
    );
    modport slave (
        input  A_in, B_in, start_mult, start_div, is_unsigned,
        output HI_out, LO_out, busy, done, div_zero
    );
`else
    modport master (
        output A_in, B_in, start_mult, start_div,
        input  HI_out, LO_out, busy, done, div_zero
    );
    modport slave (
        input  A_in, B_in, start_mult, start_div,
        output HI_out, LO_out, busy, done, div_zero
    );
`endif
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV engine owning HI/LO: radix-2 Booth multiply, restoring divide.
// Optional MULTDIV_UNSIGNED_EN adds MULTU/DIVU selected by is_unsigned at start.
module mult_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W:0]     acc_q, acc_d;      // Booth accumulator / partial remainder
    logic [DATA_W-1:0]   mq_q, mq_d;        // multiplier / dividend shifting into quotient
    logic                qm1_q, qm1_d;
    logic [DATA_W:0]     mcand_q, mcand_d;  // multiplicand or divisor magnitude
    logic                is_div_q, is_div_d;
    logic                fix_q, fix_d;
    logic                q_neg_q, q_neg_d;
    logic                r_neg_q, r_neg_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;
    logic                dz_q, dz_d;

    logic                uns_req;
    logic                a_neg, b_neg;
    logic [DATA_W:0]     booth_sum;
    logic [DATA_W:0]     rem_sh;
    logic [DATA_W+1:0]   rem_diff;

`ifdef MULTDIV_UNSIGNED_EN
    assign uns_req = bus.is_unsigned;
`else
    assign uns_req = 1'b0;
`endif

    assign a_neg = ~uns_req & bus.A_in[DATA_W-1];
    assign b_neg = ~uns_req & bus.B_in[DATA_W-1];

    // NOTE: every variable gets its hold/default value first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        qm1_d     = qm1_q;
        mcand_d   = mcand_q;
        is_div_d  = is_div_q;
        fix_d     = fix_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        booth_sum = acc_q;
        rem_sh    = {acc_q[DATA_W-1:0], mq_q[DATA_W-1]};
        rem_diff  = {1'b0, rem_sh} - {1'b0, mcand_q};

        case (state_q)
            IDLE: begin
                if (bus.start_mult) begin
                    state_d  = MULT;
                    cnt_d    = '0;
                    acc_d    = '0;
                    qm1_d    = 1'b0;
                    mq_d     = bus.B_in;
                    mcand_d  = {~uns_req & bus.A_in[DATA_W-1], bus.A_in};
                    // Booth treats B as signed; an unsigned B with its MSB set needs A<<32 added back.
                    fix_d    = uns_req & bus.B_in[DATA_W-1];
                    is_div_d = 1'b0;
                end else if (bus.start_div) begin
                    if (bus.B_in == '0) begin
                        dz_d = 1'b1;
                    end else begin
                        state_d  = DIV;
                        cnt_d    = '0;
                        acc_d    = '0;
                        qm1_d    = 1'b0;
                        mq_d     = a_neg ? -bus.A_in : bus.A_in;
                        mcand_d  = {1'b0, (b_neg ? -bus.B_in : bus.B_in)};
                        q_neg_d  = a_neg ^ b_neg;
                        r_neg_d  = a_neg;
                        fix_d    = 1'b0;
                        is_div_d = 1'b1;
                    end
                end
            end
            MULT: begin
                case ({mq_q[0], qm1_q})
                    2'b01:   booth_sum = acc_q + mcand_q;
                    2'b10:   booth_sum = acc_q - mcand_q;
                    default: booth_sum = acc_q;
                endcase
                {acc_d, mq_d, qm1_d} = {booth_sum[DATA_W], booth_sum, mq_q};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) state_d = FINISH;
            end
            DIV: begin
                if (!rem_diff[DATA_W+1]) acc_d = rem_diff[DATA_W:0];
                else                     acc_d = rem_sh;
                mq_d  = {mq_q[DATA_W-2:0], ~rem_diff[DATA_W+1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) state_d = FINISH;
            end
            FINISH: begin
                if (is_div_q) begin
                    lo_d = q_neg_q ? -mq_q : mq_q;
                    hi_d = r_neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
                end else begin
                    lo_d = mq_q;
                    hi_d = acc_q[DATA_W-1:0] + (fix_q ? mcand_q[DATA_W-1:0] : '0);
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            qm1_q    <= 1'b0;
            mcand_q  <= '0;
            is_div_q <= 1'b0;
            fix_q    <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            qm1_q    <= qm1_d;
            mcand_q  <= mcand_d;
            is_div_q <= is_div_d;
            fix_q    <= fix_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.HI_out   = hi_q;
    assign bus.LO_out   = lo_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
endmodule
